half_adder_unit: RTL and testbench

- Bitwise half adder: WIDTH independent lanes, each adding two 1-bit operands into a sum bit and a carry bit.
- Provides zero-latency combinational results and a one-cycle registered copy with a valid flag.
- A saturating counter records how many accepted cycles produced any carry.
- Used as a leaf arithmetic primitive in the TD4-style datapath and as a building block for full adders and ripple adders.

---
 rtl/half_adder_unit_if.sv | 26 ++
 rtl/half_adder_unit.sv | 45 ++++
 tb/tb_half_adder_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/half_adder_unit_if.sv
// half_adder_unit_if: operand, result and counter bundle for the half-adder unit
interface half_adder_unit_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;
    logic             in_valid;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] c_q;
    logic             out_valid;
    logic [CNT_W-1:0] carry_cnt;
    logic             clr_cnt;

    modport master (
        output a, b, in_valid, clr_cnt,
        input  s, c, s_q, c_q, out_valid, carry_cnt
    );

    modport slave (
        input  a, b, in_valid, clr_cnt,
        output s, c, s_q, c_q, out_valid, carry_cnt
    );
endinterface

// File: rtl/half_adder_unit.sv
// half_adder_unit: per-lane half adders with registered copy and saturating carry-event counter
module half_adder_unit #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    half_adder_unit_if.slave  bus
);
    logic [WIDTH-1:0] s_d, s_q;
    logic [WIDTH-1:0] c_d, c_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign bus.s         = bus.a ^ bus.b;
    assign bus.c         = bus.a & bus.b;
    assign bus.s_q       = s_q;
    assign bus.c_q       = c_q;
    assign bus.out_valid = valid_q;
    assign bus.carry_cnt = cnt_q;

    // capture on in_valid, otherwise hold; counter clear beats increment, increment stops at all-ones
    always_comb begin
        s_d     = bus.in_valid ? bus.s : s_q;
        c_d     = bus.in_valid ? bus.c : c_q;
        valid_d = bus.in_valid;
        cnt_d   = bus.clr_cnt ? '0 :
                  (bus.in_valid && (|bus.c) && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    end

    // state registers, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            c_q     <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s_q     <= s_d;
            c_q     <= c_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_half_adder_unit.sv
// tb_half_adder_unit: directed scoreboard bench for half_adder_unit
module tb_half_adder_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    half_adder_unit_if #(.WIDTH(1), .CNT_W(8)) b1 ();
    half_adder_unit_if #(.WIDTH(4), .CNT_W(2)) b4 ();

    half_adder_unit #(.WIDTH(1), .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    half_adder_unit #(.WIDTH(4), .CNT_W(2)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    typedef struct packed {
        logic [3:0] s;
        logic [3:0] c;
    } res_t;

    res_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         cnt_m  = 0;
    logic       vm     = 1'b0;
    logic [3:0] last_s = '0;
    logic [3:0] last_c = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step4(input logic [3:0] a, input logic [3:0] b, input logic v, input logic clr);
        res_t r;
        @(negedge clk);
        b4.a = a; b4.b = b; b4.in_valid = v; b4.clr_cnt = clr;
        if (v) sb.push_back({a ^ b, a & b});
        @(posedge clk);
        #1;
        cnt_m = clr ? 0 : (v && (a & b) != 4'd0 && cnt_m < 3) ? cnt_m + 1 : cnt_m;
        vm = v;
        chk("out_valid", {31'd0, b4.out_valid}, {31'd0, vm});
        if (b4.out_valid === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow: got out_valid=1 want queued result");
            end
            if (sb.size() != 0) begin
                r = sb.pop_front();
                last_s = r.s;
                last_c = r.c;
            end
        end
        chk("s_q", {28'd0, b4.s_q}, {28'd0, last_s});
        chk("c_q", {28'd0, b4.c_q}, {28'd0, last_c});
        chk("carry_cnt", {30'd0, b4.carry_cnt}, cnt_m);
    endtask

    logic [1:0] tt_in  [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic [1:0] tt_out [4] = '{2'b00, 2'b10, 2'b10, 2'b01};

    initial begin
        rst_n = 1'b0;
        b1.a = '0; b1.b = '0; b1.in_valid = 1'b0; b1.clr_cnt = 1'b0;
        b4.a = '0; b4.b = '0; b4.in_valid = 1'b0; b4.clr_cnt = 1'b0;
        #1;
        chk("rst_s_q", {28'd0, b4.s_q}, 0);
        chk("rst_c_q", {28'd0, b4.c_q}, 0);
        chk("rst_out_valid", {31'd0, b4.out_valid}, 0);
        chk("rst_cnt", {30'd0, b4.carry_cnt}, 0);
        b1.a = 1'b1; b1.b = 1'b1;
        #1;
        chk("rst_live_s", {31'd0, b1.s}, 0);
        chk("rst_live_c", {31'd0, b1.c}, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            b1.a = tt_in[i][1]; b1.b = tt_in[i][0];
            #10;
            chk("tt_s", {31'd0, b1.s}, {31'd0, tt_out[i][1]});
            chk("tt_c", {31'd0, b1.c}, {31'd0, tt_out[i][0]});
        end
        b1.a = 1'bx; b1.b = 1'b0;
        #1;
        chk("x_s", {31'd0, b1.s}, {31'd0, 1'bx});
        chk("x_c_and0", {31'd0, b1.c}, 0);
        b1.b = 1'b1;
        #1;
        chk("x_c_and1", {31'd0, b1.c}, {31'd0, 1'bx});
        b1.a = 1'b0; b1.b = 1'b0;

        b4.a = 4'b1100; b4.b = 4'b1010;
        #1;
        chk("lane_s", {28'd0, b4.s}, 32'b0110);
        chk("lane_c", {28'd0, b4.c}, 32'b1000);

        step4(4'b0001, 4'b0001, 1'b1, 1'b0);
        step4(4'b0001, 4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step4(4'b0011, 4'b0001, 1'b1, 1'b0);
        step4(4'b0001, 4'b0001, 1'b1, 1'b1);
        step4(4'b0001, 4'b0000, 1'b1, 1'b0);
        step4(4'b1111, 4'b1111, 1'b1, 1'b0);
        step4(4'b1010, 4'b0101, 1'b1, 1'b0);
        step4(4'b0000, 4'b0000, 1'b0, 1'b0);

        step4(4'b1111, 4'b0110, 1'b1, 1'b0);
        @(negedge clk);
        b4.in_valid = 1'b0; b4.clr_cnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_s_q", {28'd0, b4.s_q}, 0);
        chk("mid_rst_c_q", {28'd0, b4.c_q}, 0);
        chk("mid_rst_out_valid", {31'd0, b4.out_valid}, 0);
        chk("mid_rst_cnt", {30'd0, b4.carry_cnt}, 0);
        b4.a = 4'b1010; b4.b = 4'b0110;
        #1;
        chk("mid_rst_live_s", {28'd0, b4.s}, 32'b1100);
        chk("mid_rst_live_c", {28'd0, b4.c}, 32'b0010);
        rst_n = 1'b1;
        sb.delete();
        vm = 1'b0; cnt_m = 0; last_s = '0; last_c = '0;

        step4(4'b0110, 4'b0011, 1'b1, 1'b0);
        step4(4'b0000, 4'b0000, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b1.a = 1'b1; b1.b = 1'b1; b1.in_valid = 1'b1;
        end
        @(negedge clk);
        b1.in_valid = 1'b0;
        chk("w1_cnt", {24'd0, b1.carry_cnt}, 3);
        chk("w1_s_q", {31'd0, b1.s_q}, 0);
        chk("w1_c_q", {31'd0, b1.c_q}, 1);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: got %0d pending want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
